dfu_bank_rd_sched: RTL and testbench
====================================

Name: dfu_bank_rd_sched

Overview:
- Controller in front of one DFU SRAM bank (Es-bit words, 2**sram_addr deep; combinational read, synchronous write).
- Accepts a write stream from the loader and burst read commands from the operand feeder.
- Issues at most one write and one read to the bank per cycle and resolves same-address hazards.
- Returns read data through a registered valid/ready output stage that honours backpressure.

Parameters:
- Es, 16, bank word width in bits.
- sram_addr, 8, bank address width; depth = 2**sram_addr.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- wr_vld  in  1  loader write request.
- wr_rdy  out  1  write accepted when wr_vld&&wr_rdy; constant 1.
- wr_addr  in  sram_addr  write address.
- wr_data  in  Es  write data.
- cmd_vld  in  1  read burst command valid.
- cmd_rdy  out  1  high only in IDLE.
- cmd_base  in  sram_addr  first read address.
- cmd_len  in  sram_addr+1  number of words, 0..2**sram_addr.
- sram_wr_en  out  1  bank write enable.
- sram_wr_addr  out  sram_addr  bank write address.
- sram_wr_data  out  Es  bank write data.
- sram_rd_en  out  1  bank read enable.
- sram_rd_addr  out  sram_addr  bank read address.
- sram_rd_data  in  Es  bank read data, same cycle as sram_rd_en.
- out_vld  out  1  read data valid.
- out_rdy  in  1  consumer ready.
- out_data  out  Es  read data.
- out_last  out  1  final word of burst, qualified by out_vld.
- busy  out  1  FSM not IDLE or out_vld high.
- done  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset when rst==0 at posedge clk:
  - FSM goes to IDLE; address and remaining-count registers clear.
  - out_vld=0, out_data=0, out_last=0, done=0.
  - Any in-flight burst is discarded. No done pulse is generated for it.
  - sram_* outputs are combinational and gated low by reset state.
- Write path is pure pass-through and never stalls:
  - sram_wr_en = wr_vld.
  - sram_wr_addr = wr_addr.
  - sram_wr_data = wr_data.
- FSM states:
  - IDLE: cmd_rdy=1. On cmd accept with cmd_len!=0: load addr=cmd_base, rem=cmd_len, go to RD. With cmd_len==0: go to FIN, no reads.
  - RD: issue one read per cycle when slot_free && !hazard. slot_free = !out_vld || out_rdy. On issue: addr increments modulo 2**sram_addr (wraps 2**sram_addr-1 -> 0) and rem decrements. When the issue has rem==1, go to FIN.
  - FIN: wait until out_vld==0, or out_vld&&out_rdy this cycle. Then pulse done for one cycle and return to IDLE. A new command is accepted the cycle after done.
- Hazard rule: hazard = wr_vld && wr_addr==addr in RD.
  - On hazard, no read issues that cycle (sram_rd_en=0). The write lands first, so the next-cycle read returns new data.
  - A write to any other address never stalls reads.
- sram_rd_en = issue; sram_rd_addr = addr.
- On issue, out_data <= sram_rd_data, out_vld <= 1, out_last <= (rem==1).
- If out_vld && out_rdy and no issue that cycle, out_vld <= 0.
- Latency: command accept to first out_vld = 2 cycles with no stalls.
- Throughput: 1 word/cycle with out_rdy held high.
- out_data and out_last hold stable while out_vld && !out_rdy.
- cmd_len = 2**sram_addr reads the whole bank once, wrapping back to cmd_base.

Optional Feature:
- Macro: DFU_HAZARD_BYPASS_EN.
- Defined:
  - The hazard never stalls.
  - The read issues that cycle and out_data captures wr_data instead of sram_rd_data.
  - Throughput stays 1 word/cycle under any write pattern.
- Undefined: the stall behaviour above applies.

Decomposition:
- Shared package dfu_pkg holds:
  - FSM state encoding (IDLE=2'd0, RD=2'd1, FIN=2'd2).
  - Default Es and sram_addr constants, shared with the sram bank.
- One natural sub-module: dfu_out_skid, the registered valid/ready output stage holding out_data/out_last.
- Address/count sequencing and the FSM stay in the top module.

Test Plan:
- Write 0xA0+i to addr i for i=0..7, then cmd base=0 len=8, out_rdy=1:
  - out_data = 0xA0..0xA7 on consecutive cycles.
  - out_last with 0xA7.
  - done pulse one cycle after the last handshake.
- cmd base=254 len=4 (sram_addr=8): sram_rd_addr sequence 254,255,0,1 (wrap); out_last on 4th word.
- Burst len=4 with out_rdy toggled 1,0,0,1,...:
  - no word dropped or duplicated.
  - out_data stable while stalled.
  - sram_rd_en only when slot free.
- During a burst at addr 5 (old value 0x11), drive wr_vld with addr=5, data=0x55:
  - without macro: one stall cycle, then out_data=0x55.
  - with DFU_HAZARD_BYPASS_EN: no stall, out_data=0x55.
- cmd len=0: no sram_rd_en, no out_vld; done pulses; cmd_rdy returns to 1.
- Assert rst=0 mid-burst after 2 of 6 words:
  - next cycle out_vld=0, busy=0, cmd_rdy=1, no done pulse.
  - a new burst afterwards completes correctly.

Source files
------------

// File: rtl/dfu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dfu_pkg
//  Description : Shared types and default sizes for the DFU bank read
//                scheduler and the SRAM bank it fronts.
//  Revision    : 1.0 - initial release
// ============================================================================
package dfu_pkg;

    // Default bank geometry, shared with the SRAM bank instance.
    localparam int ES_DEFAULT        = 16;
    localparam int SRAM_ADDR_DEFAULT = 8;

    // Read-burst sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_FIN  = 2'd2
    } dfu_state_e;

endpackage : dfu_pkg
`default_nettype wire

// File: rtl/dfu_out_skid.sv
`default_nettype none
// ============================================================================
//  Module      : dfu_out_skid
//  Description : Registered valid/ready output stage for bank read data.
//                Holds out_data/out_last stable while the consumer stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module dfu_out_skid
    import dfu_pkg::*;
#(
    parameter int Es = ES_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [Es-1:0] load_data,
    input  logic          load_last,
    input  logic          out_rdy,
    output logic          out_vld,
    output logic [Es-1:0] out_data,
    output logic          out_last
);

    logic          vld_d,  vld_q;
    logic [Es-1:0] data_d, data_q;
    logic          last_d, last_q;

    // Capture a new word on load, retire on handshake, otherwise hold.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        last_d = last_q;
        if (load) begin
            vld_d  = 1'b1;
            data_d = load_data;
            last_d = load_last;
        end else if (vld_q && out_rdy) begin
            vld_d  = 1'b0;
        end
    end

    // Output register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            last_q <= last_d;
        end
    end

    assign out_vld  = vld_q;
    assign out_data = data_q;
    assign out_last = last_q;

endmodule : dfu_out_skid
`default_nettype wire

// File: rtl/dfu_bank_rd_sched.sv
`default_nettype none
// ============================================================================
//  Module      : dfu_bank_rd_sched
//  Description : Scheduler in front of one DFU SRAM bank. Passes the loader
//                write stream straight through, sequences burst reads, stalls
//                a read whose address is being written this cycle, and
//                returns data through a registered valid/ready stage.
//                Optional macro DFU_HAZARD_BYPASS_EN: instead of stalling on
//                a same-address write, forward the write data into the read.
//  Revision    : 1.0 - initial release
// ============================================================================
module dfu_bank_rd_sched
    import dfu_pkg::*;
#(
    parameter int Es        = ES_DEFAULT,
    parameter int sram_addr = SRAM_ADDR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_vld,
    output logic                 wr_rdy,
    input  logic [sram_addr-1:0] wr_addr,
    input  logic [Es-1:0]        wr_data,
    input  logic                 cmd_vld,
    output logic                 cmd_rdy,
    input  logic [sram_addr-1:0] cmd_base,
    input  logic [sram_addr:0]   cmd_len,
    output logic                 sram_wr_en,
    output logic [sram_addr-1:0] sram_wr_addr,
    output logic [Es-1:0]        sram_wr_data,
    output logic                 sram_rd_en,
    output logic [sram_addr-1:0] sram_rd_addr,
    input  logic [Es-1:0]        sram_rd_data,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [Es-1:0]        out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam logic [sram_addr:0] REM_ONE = {{sram_addr{1'b0}}, 1'b1};

    dfu_state_e           state_d, state_q;
    logic [sram_addr-1:0] addr_d,  addr_q;
    logic [sram_addr:0]   rem_d,   rem_q;
    logic                 done_d,  done_q;

    logic                 hazard;
    logic                 slot_free;
    logic                 issue;
    logic                 rem_last;
    logic [Es-1:0]        rd_word;

    // Writes never stall: the bank sees the loader stream unchanged.
    assign wr_rdy       = 1'b1;
    assign sram_wr_en   = wr_vld;
    assign sram_wr_addr = wr_addr;
    assign sram_wr_data = wr_data;

    // Read issue decision: needs a free output slot and no same-address write.
    always_comb begin
        hazard    = (state_q == ST_RD) && wr_vld && (wr_addr == addr_q);
        slot_free = !out_vld || out_rdy;
        rem_last  = (rem_q == REM_ONE);
`ifdef DFU_HAZARD_BYPASS_EN
        // The colliding write is forwarded, so the read never waits.
        issue     = (state_q == ST_RD) && slot_free;
        rd_word   = hazard ? wr_data : sram_rd_data;
`else
        // Hold the read one cycle so the write lands before the bank is read.
        issue     = (state_q == ST_RD) && slot_free && !hazard;
        rd_word   = sram_rd_data;
`endif
    end

    // Burst sequencer next state: address/count walk and completion pulse.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_vld) begin
                    if (cmd_len != '0) begin
                        addr_d  = cmd_base;
                        rem_d   = cmd_len;
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_RD: begin
                if (issue) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_last) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                // Complete once the last word has left (or is leaving) the stage.
                if (slot_free) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; reset discards any in-flight burst silently.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign cmd_rdy      = (state_q == ST_IDLE);
    assign sram_rd_en   = issue;
    assign sram_rd_addr = addr_q;
    assign busy         = (state_q != ST_IDLE) || out_vld;
    assign done         = done_q;

    dfu_out_skid #(
        .Es (Es)
    ) u_out_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (issue),
        .load_data (rd_word),
        .load_last (rem_last),
        .out_rdy   (out_rdy),
        .out_vld   (out_vld),
        .out_data  (out_data),
        .out_last  (out_last)
    );

endmodule : dfu_bank_rd_sched
`default_nettype wire

// File: tb/tb_dfu_bank_rd_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dfu_bank_rd_sched
//  Description : Self-checking bench for dfu_bank_rd_sched with a behavioural
//                SRAM bank and a shadow memory giving expected read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dfu_bank_rd_sched;

    localparam int ES = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_vld = 1'b0;
    logic          wr_rdy;
    logic [AW-1:0] wr_addr = '0;
    logic [ES-1:0] wr_data = '0;
    logic          cmd_vld = 1'b0;
    logic          cmd_rdy;
    logic [AW-1:0] cmd_base = '0;
    logic [AW:0]   cmd_len = '0;
    logic          sram_wr_en;
    logic [AW-1:0] sram_wr_addr;
    logic [ES-1:0] sram_wr_data;
    logic          sram_rd_en;
    logic [AW-1:0] sram_rd_addr;
    logic [ES-1:0] sram_rd_data;
    logic          out_vld;
    logic          out_rdy = 1'b1;
    logic [ES-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    dfu_bank_rd_sched #(.Es(ES), .sram_addr(AW)) dut (
        .clk(clk), .rst(rst),
        .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_addr(wr_addr), .wr_data(wr_data),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
        .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural bank: synchronous write, combinational read.
    logic [ES-1:0] bank [256];
    always @(posedge clk) if (sram_wr_en) bank[sram_wr_addr] <= sram_wr_data;
    assign sram_rd_data = bank[sram_rd_addr];

    // Shadow of what the bank should hold, maintained by the stimulus.
    logic [ES-1:0] exp_mem [256];

    // Observation records.
    logic [ES-1:0] rx_data [$];
    logic          rx_last [$];
    logic [AW-1:0] rd_addrs [$];
    int  done_cnt, vld_cnt, slot_err, stab_err, first_vld_cyc, last_hs_cyc, done_cyc;
    bit  mon_en = 1'b0;
    logic          prev_stall = 1'b0;
    logic [ES-1:0] prev_data;
    logic          prev_last;

    // Record handshakes, bank reads, done pulses and stall-stability breaks.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_vld && out_rdy) begin
                rx_data.push_back(out_data);
                rx_last.push_back(out_last);
                last_hs_cyc = cyc;
            end
            if (out_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (out_vld) vld_cnt++;
            if (sram_rd_en) begin
                rd_addrs.push_back(sram_rd_addr);
                if (out_vld && !out_rdy) slot_err++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_stall && (!out_vld || out_data !== prev_data || out_last !== prev_last)) stab_err++;
            prev_stall = out_vld && !out_rdy;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_records();
        rx_data.delete(); rx_last.delete(); rd_addrs.delete();
        done_cnt = 0; vld_cnt = 0; slot_err = 0; stab_err = 0;
        first_vld_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [ES-1:0] d);
        wr_vld = 1'b1; wr_addr = a; wr_data = d; exp_mem[a] = d;
        @(posedge clk); #1;
        wr_vld = 1'b0;
    endtask

    // Issue one command and run until done (or a cycle budget expires).
    // mode: 0 = ready always, 1 = ready pattern 1,0,0,1, 2 = random ready.
    task automatic run_burst(input logic [AW-1:0] base, input logic [AW:0] len, input int mode,
                             input int inj_off, input logic [AW-1:0] inj_addr, input logic [ES-1:0] inj_data,
                             input bit rnd_wr, output bit tmo, output int acc_cyc, output bit inj_rd_en);
        logic [3:0] pat;
        int off;
        pat = 4'b1001;
        clear_records();
        mon_en = 1'b1; tmo = 1'b1; acc_cyc = -1; inj_rd_en = 1'b0;
        cmd_vld = 1'b1; cmd_base = base; cmd_len = len;
        for (int k = 0; k < 1200; k++) begin
            out_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[k % 4] : 1'($urandom % 2);
            wr_vld = 1'b0;
            if (k == inj_off) begin
                wr_vld = 1'b1; wr_addr = inj_addr; wr_data = inj_data; exp_mem[inj_addr] = inj_data;
            end else if (rnd_wr && len < 9'd256 && ($urandom % 3) == 0) begin
                off = int'($urandom_range(255, int'(len)));
                wr_vld = 1'b1; wr_addr = AW'(int'(base) + off); wr_data = ES'($urandom);
                exp_mem[wr_addr] = wr_data;
            end
            @(negedge clk);
            if (k == inj_off) inj_rd_en = sram_rd_en;
            if (k == 0 && cmd_vld && cmd_rdy) acc_cyc = cyc;
            #1;
            if (done_cnt > 0) begin
                tmo = 1'b0;
                break;
            end
            @(posedge clk); #1;
            cmd_vld = 1'b0;
        end
        @(posedge clk); #1;
        cmd_vld = 1'b0; wr_vld = 1'b0; out_rdy = 1'b1; mon_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld: got %0b want 0", out_vld); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %0b want 0", out_last); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_rdy: got %0b want 1", cmd_rdy); end
        n_checks++; if (sram_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %0b want 0", sram_rd_en); end
        n_checks++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_wr_rdy: got %0b want 1", wr_rdy); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_basic_burst();
        bit tmo, ird; int acc;
        wr_vld = 1'b1; wr_addr = 8'h3C; wr_data = 16'hBEEF; exp_mem[8'h3C] = 16'hBEEF;
        @(negedge clk);
        n_checks++; if ({sram_wr_en, sram_wr_addr, sram_wr_data} !== {1'b1, 8'h3C, 16'hBEEF}) begin
            n_fail++; $display("FAIL wr_passthru: got en=%0b a=%h d=%h want 1 3c beef", sram_wr_en, sram_wr_addr, sram_wr_data); end
        @(posedge clk); #1;
        wr_vld = 1'b0;
        for (int i = 0; i < 8; i++) write_word(AW'(i), ES'(32'hA0 + i));
        run_burst(8'd0, 9'd8, 0, -1, '0, '0, 1'b0, tmo, acc, ird);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %0b want 0", tmo); end
        n_checks++; if (rx_data.size() != 8) begin n_fail++; $display("FAIL basic_count: got %0d want 8", rx_data.size()); end
        for (int i = 0; i < rx_data.size(); i++) begin
            n_checks++; if (rx_data[i] !== ES'(32'hA0 + i)) begin n_fail++; $display("FAIL basic_data[%0d]: got %h want %h", i, rx_data[i], ES'(32'hA0 + i)); end
            n_checks++; if (rx_last[i] !== (i == 7)) begin n_fail++; $display("FAIL basic_last[%0d]: got %0b want %0b", i, rx_last[i], (i == 7)); end
        end
        n_checks++; if (first_vld_cyc != acc + 2) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", first_vld_cyc - acc, 2); end
        n_checks++; if (done_cyc != last_hs_cyc + 1) begin n_fail++; $display("FAIL basic_done_timing: got %0d want %0d", done_cyc, last_hs_cyc + 1); end
        n_checks++; if (done_cyc - acc != 10) begin n_fail++; $display("FAIL basic_throughput: got %0d want 10", done_cyc - acc); end
    endtask

    task automatic test_wrap();
        bit tmo, ird; int acc;
        logic [AW-1:0] exp_a [4];
        exp_a = '{8'd254, 8'd255, 8'd0, 8'd1};
        run_burst(8'd254, 9'd4, 0, -1, '0, '0, 1'b0, tmo, acc, ird);
        n_checks++; if (rd_addrs.size() != 4) begin n_fail++; $display("FAIL wrap_rd_count: got %0d want 4", rd_addrs.size()); end
        n_checks++; if (rx_data.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", rx_data.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < rd_addrs.size()) begin
                n_checks++; if (rd_addrs[i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, rd_addrs[i], exp_a[i]); end
            end
            if (i < rx_data.size()) begin
                n_checks++; if (rx_data[i] !== exp_mem[exp_a[i]]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, rx_data[i], exp_mem[exp_a[i]]); end
                n_checks++; if (rx_last[i] !== (i == 3)) begin n_fail++; $display("FAIL wrap_last[%0d]: got %0b want %0b", i, rx_last[i], (i == 3)); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit tmo, ird; int acc;
        run_burst(8'd20, 9'd4, 1, -1, '0, '0, 1'b0, tmo, acc, ird);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %0b want 0", tmo); end
        n_checks++; if (rx_data.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", rx_data.size()); end
        for (int i = 0; i < rx_data.size(); i++) begin
            n_checks++; if (rx_data[i] !== exp_mem[20 + i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, rx_data[i], exp_mem[20 + i]); end
        end
        n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", stab_err); end
        n_checks++; if (slot_err != 0) begin n_fail++; $display("FAIL bp_rd_slot: got %0d reads into full slot want 0", slot_err); end
        n_checks++; if (rd_addrs.size() != 4) begin n_fail++; $display("FAIL bp_rd_count: got %0d want 4", rd_addrs.size()); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_hazard();
        bit tmo, ird; int acc;
        int exp_dur; bit exp_rd;
`ifdef DFU_HAZARD_BYPASS_EN
        exp_dur = 6; exp_rd = 1'b1;
`else
        exp_dur = 7; exp_rd = 1'b0;
`endif
        write_word(8'd5, 16'h0011);
        // Reads of 3,4 issue in the first two RD cycles; the write hits addr 5 on the third.
        run_burst(8'd3, 9'd4, 0, 3, 8'd5, 16'h0055, 1'b0, tmo, acc, ird);
        n_checks++; if (ird !== exp_rd) begin n_fail++; $display("FAIL hazard_rd_en: got %0b want %0b", ird, exp_rd); end
        n_checks++; if (rx_data.size() != 4) begin n_fail++; $display("FAIL hazard_count: got %0d want 4", rx_data.size()); end
        if (rx_data.size() > 2) begin
            n_checks++; if (rx_data[2] !== 16'h0055) begin n_fail++; $display("FAIL hazard_new_data: got %h want 0055", rx_data[2]); end
        end
        for (int i = 0; i < rx_data.size(); i++) begin
            n_checks++; if (rx_data[i] !== exp_mem[3 + i]) begin n_fail++; $display("FAIL hazard_data[%0d]: got %h want %h", i, rx_data[i], exp_mem[3 + i]); end
        end
        n_checks++; if (done_cyc - acc != exp_dur) begin n_fail++; $display("FAIL hazard_duration: got %0d want %0d", done_cyc - acc, exp_dur); end
        n_checks++; if (rd_addrs.size() != 4) begin n_fail++; $display("FAIL hazard_rd_count: got %0d want 4", rd_addrs.size()); end
    endtask

    task automatic test_len0();
        bit tmo, ird; int acc;
        run_burst(8'd9, 9'd0, 0, -1, '0, '0, 1'b0, tmo, acc, ird);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL len0_timeout: got %0b want 0", tmo); end
        n_checks++; if (rd_addrs.size() != 0) begin n_fail++; $display("FAIL len0_rd_en: got %0d reads want 0", rd_addrs.size()); end
        n_checks++; if (vld_cnt != 0) begin n_fail++; $display("FAIL len0_out_vld: got %0d valid cycles want 0", vld_cnt); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL len0_done: got %0d want 1", done_cnt); end
        n_checks++; if (done_cyc - acc != 2) begin n_fail++; $display("FAIL len0_done_timing: got %0d want 2", done_cyc - acc); end
        n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL len0_cmd_rdy: got %0b want 1", cmd_rdy); end
    endtask

    task automatic test_reset_midburst();
        bit tmo, ird, got2; int acc;
        clear_records();
        got2 = 1'b0;
        mon_en = 1'b1; out_rdy = 1'b1;
        cmd_vld = 1'b1; cmd_base = 8'd40; cmd_len = 9'd6;
        @(posedge clk); #1;
        cmd_vld = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (rx_data.size() >= 2) begin got2 = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_checks++; if (got2 !== 1'b1) begin n_fail++; $display("FAIL rstmid_two_words: got %0d words want 2", rx_data.size()); end
        @(posedge clk); #1;
        mon_en = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_vld: got %0b want 0", out_vld); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
        n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL rstmid_cmd_rdy: got %0b want 1", cmd_rdy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %0b want 0", done); end
        done_cnt = 0; mon_en = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        mon_en = 1'b0;
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt); end
        run_burst(8'd100, 9'd6, 2, -1, '0, '0, 1'b0, tmo, acc, ird);
        n_checks++; if (rx_data.size() != 6) begin n_fail++; $display("FAIL rstmid_after_count: got %0d want 6", rx_data.size()); end
        for (int i = 0; i < rx_data.size(); i++) begin
            n_checks++; if (rx_data[i] !== exp_mem[100 + i] || rx_last[i] !== (i == 5)) begin
                n_fail++; $display("FAIL rstmid_after[%0d]: got %h/%0b want %h/%0b", i, rx_data[i], rx_last[i], exp_mem[100 + i], (i == 5)); end
        end
    endtask

    task automatic test_full_bank();
        bit tmo, ird; int acc;
        logic [AW-1:0] base;
        base = AW'($urandom);
        run_burst(base, 9'd256, 0, -1, '0, '0, 1'b0, tmo, acc, ird);
        n_checks++; if (rx_data.size() != 256) begin n_fail++; $display("FAIL full_count: got %0d want 256", rx_data.size()); end
        for (int i = 0; i < rx_data.size(); i++) begin
            n_checks++; if (rx_data[i] !== exp_mem[AW'(int'(base) + i)] || rx_last[i] !== (i == 255)) begin
                n_fail++; $display("FAIL full_word[%0d]: got %h/%0b want %h/%0b", i, rx_data[i], rx_last[i], exp_mem[AW'(int'(base) + i)], (i == 255)); end
        end
        n_checks++; if (done_cyc - acc != 258) begin n_fail++; $display("FAIL full_throughput: got %0d want 258", done_cyc - acc); end
    endtask

    task automatic test_random();
        bit tmo, ird; int acc, mode, len;
        logic [AW-1:0] base;
        for (int it = 0; it < 12; it++) begin
            base = AW'($urandom);
            len  = int'($urandom_range(24, 1));
            mode = int'($urandom_range(2, 0));
            run_burst(base, (AW+1)'(len), mode, -1, '0, '0, 1'b1, tmo, acc, ird);
            n_checks++; if (tmo !== 1'b0 || done_cnt != 1) begin n_fail++; $display("FAIL rnd%0d_done: got tmo=%0b pulses=%0d want 0/1", it, tmo, done_cnt); end
            n_checks++; if (rx_data.size() != len || rd_addrs.size() != len) begin
                n_fail++; $display("FAIL rnd%0d_count: got %0d words %0d reads want %0d", it, rx_data.size(), rd_addrs.size(), len); end
            for (int i = 0; i < rx_data.size(); i++) begin
                n_checks++; if (rx_data[i] !== exp_mem[AW'(int'(base) + i)] || rx_last[i] !== (i == len - 1)) begin
                    n_fail++; $display("FAIL rnd%0d_word[%0d]: got %h/%0b want %h/%0b", it, i, rx_data[i], rx_last[i], exp_mem[AW'(int'(base) + i)], (i == len - 1)); end
            end
            for (int i = 0; i < rd_addrs.size(); i++) begin
                n_checks++; if (rd_addrs[i] !== AW'(int'(base) + i)) begin n_fail++; $display("FAIL rnd%0d_addr[%0d]: got %0d want %0d", it, i, rd_addrs[i], AW'(int'(base) + i)); end
            end
            n_checks++; if (stab_err != 0 || slot_err != 0) begin n_fail++; $display("FAIL rnd%0d_flow: got stab=%0d slot=%0d want 0/0", it, stab_err, slot_err); end
            if (mode == 0) begin
                n_checks++; if (done_cyc - acc != len + 2) begin n_fail++; $display("FAIL rnd%0d_throughput: got %0d want %0d", it, done_cyc - acc, len + 2); end
            end
        end
    endtask

    initial begin
        test_reset();
        for (int a = 0; a < 256; a++) write_word(AW'(a), ES'($urandom));
        test_basic_burst();
        test_wrap();
        test_backpressure();
        test_hazard();
        test_len0();
        test_reset_midburst();
        test_full_bank();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_dfu_bank_rd_sched
`default_nettype wire
